regfile_mp_sb: RTL
==================

REGFILE_MP_SB -- requirements
Module: regfile_mp_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: bits per register.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: register address width.
REQ-003 SHALL have parameter NUM_REGS, default 32: implemented registers, legal range 2..2^ADDR_WIDTH.
REQ-004 SHALL have parameter NUM_RD, default 2: read port count, legal range 1..4.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port wa_en  input  1  write port A enable.
REQ-009 SHALL have port wa_addr  input  ADDR_WIDTH  write port A destination.
REQ-010 SHALL have port wa_data  input  DATA_WIDTH  write port A data.
REQ-011 SHALL have ports wb_en/wb_addr/wb_data  input  1/ADDR_WIDTH/DATA_WIDTH  write port B, same meaning as A.
REQ-012 SHALL have port iss_en  input  1  issue strobe: marks iss_dest pending.
REQ-013 SHALL have port iss_dest  input  ADDR_WIDTH  register to mark pending.
REQ-014 SHALL have port rd_addr  input  NUM_RD*ADDR_WIDTH  packed read addresses, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-015 SHALL have port rd_data  output  NUM_RD*DATA_WIDTH  packed read data, same packing.
REQ-016 SHALL have port rd_busy  output  NUM_RD  per-port pending flag for addressed register.
REQ-017 SHALL have port busy_vec  output  NUM_REGS  registered scoreboard state.

Function
REQ-018 SHALL commit a write on port A/B at clk edge when en=1, addr!=0, addr<NUM_REGS; otherwise ignore it.
REQ-019 SHALL, when A and B write the same valid address in one cycle, store wb_data (B has priority).
REQ-020 SHALL hold register 0 at 0 permanently; reads of address 0 return 0 regardless of writes or bypass.
REQ-021 SHALL return 0 and rd_busy=0 for reads of address >= NUM_REGS.
REQ-022 SHALL drive rd_data combinationally from array contents (zero-latency read); written data visible next cycle when BYPASS=0.
REQ-023 SHALL, when BYPASS=1, forward same-cycle committing write data to any read port with matching address, B over A, over array.
REQ-024 SHALL set busy_vec[iss_dest] at clk edge when iss_en=1, iss_dest!=0, iss_dest<NUM_REGS.
REQ-025 SHALL clear busy_vec[r] at clk edge when any committing write targets r.
REQ-026 SHALL, when issue and committing write target the same r in one cycle, leave busy_vec[r]=1 (set wins).
REQ-027 SHALL drive rd_busy[k] = busy_vec[addr_k], masked to 0 when BYPASS=1 and a committing write to addr_k is present that cycle.
REQ-028 SHALL not reflect same-cycle issue in rd_busy (issue visible next cycle).
REQ-029 SHALL keep busy_vec[0]=0 always.

Reset
REQ-030 SHALL, on clk edge with rst=0, clear all registers and busy_vec to 0, ignoring writes and issues that cycle.
REQ-031 SHALL, with rst=0 mid-operation, produce rd_data=0 and rd_busy=0 on all ports from the following cycle until new writes.

Verification
REQ-032 Reset then write A r5=0xDEADBEEF -> next cycle read r5 = 0xDEADBEEF both ports; read r0 = 0.
REQ-033 A and B both write r7 (A=0x11, B=0x22), BYPASS=1 -> same-cycle read r7 = 0x22, next cycle 0x22.
REQ-034 Issue r3, next cycle rd_busy(r3)=1; write r3=0x5 -> that cycle rd_busy=0 and rd_data=0x5 (BYPASS=1), busy_vec[3]=0 after edge.
REQ-035 Same cycle issue r9 and write r9=0xA -> busy_vec[9]=1 after edge, stored value 0xA.
REQ-036 BYPASS=0, write r4=0x77 -> same-cycle read r4 = old value 0, next cycle 0x77; write r0=0xFF -> r0 reads 0.
REQ-037 NUM_REGS=16, write addr 20 -> no state change, read addr 20 = 0; rst=0 after filling r1..r15 -> all reads 0, busy_vec=0.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-ported register file with an issue scoreboard.
// Two write ports (B wins on collision), NUM_RD zero-latency read ports,
// optional same-cycle write-to-read forwarding, and a per-register pending
// bit that is set by an issue and cleared by a committing write.
// Register 0 and its pending bit are hard zero.
module regfile_mp_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wa_en,
  input  logic [ADDR_WIDTH-1:0]          wa_addr,
  input  logic [DATA_WIDTH-1:0]          wa_data,
  input  logic                           wb_en,
  input  logic [ADDR_WIDTH-1:0]          wb_addr,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  input  logic                           iss_en,
  input  logic [ADDR_WIDTH-1:0]          iss_dest,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  output logic [NUM_REGS-1:0]            busy_vec
);

  // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_EXT = (ADDR_WIDTH+1)'(NUM_REGS);

  // An address is writable/issuable only if it is non-zero and implemented.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && ({1'b0, a} < NUM_REGS_EXT);
  endfunction

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  logic wa_commit;
  logic wb_commit;
  logic iss_commit;

  assign wa_commit  = wa_en  && addr_ok(wa_addr);
  assign wb_commit  = wb_en  && addr_ok(wb_addr);
  assign iss_commit = iss_en && addr_ok(iss_dest);

  assign busy_vec = busy;

  // Array and scoreboard update; reset clears everything and drops that
  // cycle's writes and issues. Entry 0 is rewritten with zero every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem[r] <= '0;
      end
      busy <= '0;
    end else begin
      mem[0]  <= '0;
      busy[0] <= 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wb_commit && (wb_addr == ADDR_WIDTH'(r))) begin
          mem[r] <= wb_data;
        end else if (wa_commit && (wa_addr == ADDR_WIDTH'(r))) begin
          mem[r] <= wa_data;
        end
        if (iss_commit && (iss_dest == ADDR_WIDTH'(r))) begin
          busy[r] <= 1'b1;
        end else if ((wa_commit && (wa_addr == ADDR_WIDTH'(r))) ||
                     (wb_commit && (wb_addr == ADDR_WIDTH'(r)))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] arr_val;
    logic                  arr_busy;
    logic [DATA_WIDTH-1:0] val;
    logic                  bsy;

    assign addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Array lookup; unimplemented addresses fall through to zero/not-busy.
    always_comb begin
      arr_val  = '0;
      arr_busy = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (addr == ADDR_WIDTH'(r)) begin
          arr_val  = mem[r];
          arr_busy = busy[r];
        end
      end
    end

    if (BYPASS != 0) begin : g_fwd
      // Forward a committing write (B over A) and mask its pending bit.
      // Commit qualification already excludes register 0 and out-of-range.
      always_comb begin
        val = arr_val;
        bsy = arr_busy;
        if (wb_commit && (wb_addr == addr)) begin
          val = wb_data;
          bsy = 1'b0;
        end else if (wa_commit && (wa_addr == addr)) begin
          val = wa_data;
          bsy = 1'b0;
        end
      end
    end else begin : g_nofwd
      assign val = arr_val;
      assign bsy = arr_busy;
    end

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = val;
    assign rd_busy[k]                          = bsy;
  end

endmodule
